pe_column_drain: RTL and testbench
==================================

Name: pe_column_drain

Overview:
- Drain controller at the bottom of one systolic PE column.
- After accumulation finishes, it drives the column's shift-out enable and captures each accumulator word that leaves the bottom PE's cOut into a small FIFO.
- Captured words are presented downstream on a valid/ready stream.
- Sits directly downstream of the PE chain, between the array and the result writeback/packer.

Parameters:
- ACC_DESIRED, 32, accumulator word width (matches PE cIn/cOut).
- ROWS, 8, PEs in the column = words per drain (≥2).
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥2).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse: column accumulation complete, begin drain.
- colIn  input  ACC_DESIRED  cOut of bottom PE in the column.
- enableShiftOut  output  1  to every PE in the column; shifts the cOut chain one row down.
- busy  output  1  drain in progress (sequencer holds enableMul low while set).
- done  output  1  one-cycle pulse: all ROWS words accepted downstream.
- outData  output  ACC_DESIRED  head-of-FIFO word.
- outValid  output  1  outData valid.
- outReady  input  1  downstream accepts when outValid && outReady.

Behaviour:
- Reset (synchronous, active-high, including mid-drain):
  - state=IDLE, row counter=0, FIFO flushed (count=0, pointers=0).
  - outValid=0, outData=0, enableShiftOut=0, busy=0, done=0.
  - Words already captured are discarded.
- States: IDLE, DRAIN, FLUSH.
  - IDLE: start -> DRAIN; counter cleared.
  - DRAIN: exit when the counter reaches ROWS (see below).
  - FLUSH: exit when the FIFO is empty (see below).
- busy = (state != IDLE). start while busy is ignored.
- enableShiftOut = (state==DRAIN) && (count < FIFO_DEPTH). Combinational from registered state only; no path from outReady.
- Capture: at every rising edge with enableShiftOut=1:
  - colIn is written to the FIFO.
  - The row counter increments.
  - The PEs shift at the same edge, so the captured value is the pre-shift bottom word.
  - Word k (k=0..ROWS-1) is the result of row ROWS-1-k.
- DRAIN -> FLUSH when the capture takes the counter to ROWS. Exactly ROWS shift cycles per drain, never more.
- FIFO full (count==FIFO_DEPTH): enableShiftOut=0 and the column stalls; PE values hold because they are not enabled.
- Pop on outValid && outReady.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pop while full in the same cycle does NOT enable a shift that cycle; the shift resumes next cycle.
- outValid = (count != 0). outData = entry at the read pointer. Zero-latency show-ahead: a word written at edge N is visible from cycle N+1.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- FLUSH: when count==0, done=1 for that cycle and state -> IDLE at the next edge. done is never asserted in any other state.
- Latency with outReady held high: ROWS shift cycles, then done 1 cycle after the last pop. Total start-to-done = ROWS+2 cycles.
- Data is passed bit-exact; no arithmetic on accumulator words.

Optional Feature:
- Macro: PE_DRAIN_TAG_EN.
- Defined:
  - Adds outputs outRow [$clog2(ROWS)-1:0] and outLast [1].
  - Both are stored alongside each FIFO entry.
  - outRow = ROWS-1-k for the k-th captured word.
  - outLast=1 only on the word with k=ROWS-1.
  - Both are 0 after reset and are meaningful only while outValid=1.
- Undefined: the ports and the tag storage do not exist; all other behaviour is identical.

Test Plan:
- Basic drain: ROWS=4, FIFO_DEPTH=4, outReady=1, bench PE-chain model holds 0x11,0x22,0x33,0x44 (bottom first).
  - start -> enableShiftOut high for exactly 4 cycles.
  - outData sequence 0x11,0x22,0x33,0x44.
  - done pulses once at cycle 6 after start; busy low after.
- Backpressure: ROWS=4, FIFO_DEPTH=2, outReady=0 -> enableShiftOut stops after 2 shifts, count=2. Raise outReady -> remaining 2 words drained in order, no word lost or duplicated.
- Stutter: outReady toggles 1,0,1,0 -> every accepted word matches the model order; enableShiftOut never high with count==FIFO_DEPTH.
- Start ignored: pulse start again during DRAIN -> still exactly 4 shifts, one done pulse.
- Reset mid-drain: assert reset after 2 shifts -> next cycle outValid=0, busy=0, enableShiftOut=0. A new start drains 4 fresh words correctly.
- PE_DRAIN_TAG_EN: ROWS=4 -> outRow 3,2,1,0 and outLast 0,0,0,1 with the matching outData.

Source files
------------

// File: rtl/pe_column_drain.sv
// ---------------------------------------------------------------------------------------------
// pe_column_drain
//
// Drain controller at the bottom of one systolic PE column. Once the column has finished
// accumulating, a start pulse begins a drain: the controller raises enableShiftOut, which
// moves every PE's result one row down. At each enabled edge it captures the bottom PE's cOut
// word (colIn) into a small show-ahead FIFO. The FIFO is presented downstream as a
// valid/ready stream. done pulses once all ROWS words have been accepted downstream.
//
// Word k (k = 0..ROWS-1) leaving the column is the result of row ROWS-1-k.
//
// Parameters
//   ACC_DESIRED : accumulator word width (matches PE cIn/cOut)
//   ROWS        : PEs in the column, i.e. words per drain (>= 2)
//   FIFO_DEPTH  : output buffer entries (power of 2, >= 2)
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high; flushes the FIFO and aborts any drain
//   start          in   one-cycle pulse, column accumulation complete; ignored while busy
//   colIn          in   cOut of the bottom PE in the column
//   enableShiftOut out  shift enable to every PE in the column
//   busy           out  drain in progress
//   done           out  one-cycle pulse, every word of the drain accepted downstream
//   outData        out  head-of-FIFO word
//   outValid       out  outData holds a valid word
//   outReady       in   downstream accepts when outValid && outReady
//   outRow         out  (PE_DRAIN_TAG_EN only) source row of the head word
//   outLast        out  (PE_DRAIN_TAG_EN only) head word is the last of the drain
//
// Build option
//   PE_DRAIN_TAG_EN : when defined, each FIFO entry also stores its source row and a
//                     last-word flag, presented on outRow/outLast. When undefined, the tag
//                     ports and their storage are absent.
// ---------------------------------------------------------------------------------------------

module pe_column_drain #(
  parameter int unsigned ACC_DESIRED = 32,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ACC_DESIRED-1:0]  colIn,
  output logic                    enableShiftOut,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_DESIRED-1:0]  outData,
  output logic                    outValid,
  input  logic                    outReady
`ifdef PE_DRAIN_TAG_EN
  ,
  output logic [$clog2(ROWS)-1:0] outRow,
  output logic                    outLast
`endif
);

  localparam int unsigned CntW = $clog2(ROWS + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TagW = $clog2(ROWS);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFlush
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        row_cnt_q;
  logic [PtrW-1:0]        wr_ptr_q;
  logic [PtrW-1:0]        rd_ptr_q;
  logic [OccW-1:0]        occ_q;
  logic [ACC_DESIRED-1:0] data_q [FIFO_DEPTH];

`ifdef PE_DRAIN_TAG_EN
  logic [TagW-1:0]        row_tag_q  [FIFO_DEPTH];
  logic                   last_tag_q [FIFO_DEPTH];
`endif

  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic last_capture;

  assign fifo_full    = (occ_q == OccW'(FIFO_DEPTH));
  assign fifo_empty   = (occ_q == '0);

  // The shift enable looks only at registered state: a pop into a full FIFO frees a slot
  // for the next cycle, never the current one, so there is no outReady -> enable path.
  assign push         = (state_q == StDrain) && !fifo_full;
  assign pop          = !fifo_empty && outReady;
  assign last_capture = push && (row_cnt_q == CntW'(ROWS - 1));

  assign enableShiftOut = push;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StFlush) && fifo_empty;
  assign outValid       = !fifo_empty;
  assign outData        = data_q[rd_ptr_q];

`ifdef PE_DRAIN_TAG_EN
  assign outRow  = row_tag_q[rd_ptr_q];
  assign outLast = last_tag_q[rd_ptr_q];
`endif

  // Sequencer, row counter and FIFO share one clocked process.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
`ifdef PE_DRAIN_TAG_EN
        row_tag_q[i]  <= '0;
        last_tag_q[i] <= 1'b0;
`endif
      end
    end else begin
      // Capture the pre-shift bottom word; the PEs shift on this same edge.
      if (push) begin
        data_q[wr_ptr_q] <= colIn;
`ifdef PE_DRAIN_TAG_EN
        row_tag_q[wr_ptr_q]  <= TagW'(ROWS - 1) - row_cnt_q[TagW-1:0];
        last_tag_q[wr_ptr_q] <= last_capture;
`endif
        wr_ptr_q  <= wr_ptr_q + PtrW'(1);
        row_cnt_q <= row_cnt_q + CntW'(1);
      end

      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end

      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push && !pop) begin
        occ_q <= occ_q + OccW'(1);
      end else if (pop && !push) begin
        occ_q <= occ_q - OccW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StDrain;
            row_cnt_q <= '0;
          end
        end
        StDrain: begin
          if (last_capture) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (fifo_empty) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_column_drain.sv
// ---------------------------------------------------------------------------------------------
// tb_pe_column_drain
//
// Bench for pe_column_drain with ROWS=4, FIFO_DEPTH=2. A behavioural PE-chain model presents
// the next bottom word on colIn and advances on every enabled shift. Expected words are
// queued when a drain is started and compared as the stream hands them over. Table-driven
// drains cover several data/readiness patterns; hand-written sequences cover backpressure
// and reset mid-drain.
// ---------------------------------------------------------------------------------------------

module tb_pe_column_drain;

  localparam int unsigned W     = 32;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          outReady;
  logic [W-1:0]  colIn;
  logic          enableShiftOut;
  logic          busy;
  logic          done;
  logic [W-1:0]  outData;
  logic          outValid;
`ifdef PE_DRAIN_TAG_EN
  logic [1:0]    outRow;
  logic          outLast;
`endif

  pe_column_drain #(
    .ACC_DESIRED (W),
    .ROWS        (ROWS),
    .FIFO_DEPTH  (DEPTH)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .colIn          (colIn),
    .enableShiftOut (enableShiftOut),
    .busy           (busy),
    .done           (done),
    .outData        (outData),
    .outValid       (outValid),
    .outReady       (outReady)
`ifdef PE_DRAIN_TAG_EN
    ,
    .outRow         (outRow),
    .outLast        (outLast)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PE-chain model: colIn is word mdl_idx of the loaded column, bottom first.
  logic [3:0][W-1:0] mdl_words = '0;
  logic [2:0]        mdl_idx;

  always @(posedge clock) begin
    if (reset) begin
      mdl_idx <= '0;
    end else if (start && !busy) begin
      mdl_idx <= '0;
    end else if (enableShiftOut) begin
      mdl_idx <= mdl_idx + 3'd1;
    end
  end

  // Past the top of the column the chain would hand over junk; an extra shift shows up here.
  assign colIn = (mdl_idx < 3'(ROWS)) ? mdl_words[mdl_idx[1:0]] : 32'hDEAD_BEEF;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   row;
    logic         last;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: samples on the falling edge, away from the active edge.
  int cyc        = 0;
  int tot_shifts = 0;
  int tot_dones  = 0;
  int start_cyc  = 0;
  int done_cyc   = 0;
  int occ        = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      check("shift_while_full", (enableShiftOut && occ == DEPTH), 1'b0);
      check("valid_vs_occupancy", outValid, (occ != 0));
      if (start && !busy && !reset) start_cyc = cyc;
      if (enableShiftOut) tot_shifts++;
      if (done) begin
        tot_dones++;
        done_cyc = cyc;
      end
      if (outValid && outReady) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", outData, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("out_data", outData, e.data);
`ifdef PE_DRAIN_TAG_EN
          check("out_row", outRow, e.row);
          check("out_last", outLast, e.last);
`endif
        end
      end
      occ = occ + (enableShiftOut ? 1 : 0) - ((outValid && outReady) ? 1 : 0);
      if (reset) begin
        occ = 0;
        sb_q.delete();
      end
    end
  end

  // Load the column model, queue its expected words, raise start (called at posedge + 1).
  task automatic begin_drain(input logic [3:0][W-1:0] words);
    exp_t e;
    mdl_words = words;
    for (int k = 0; k < int'(ROWS); k++) begin
      e.data = words[k];
      e.row  = 2'(int'(ROWS) - 1 - k);
      e.last = (k == int'(ROWS) - 1);
      sb_q.push_back(e);
    end
    start = 1'b1;
  endtask

  // Full drain with a cycled 4-bit readiness pattern; optional second start while busy.
  task automatic drain(input logic [3:0][W-1:0] words, input logic [3:0] pat,
                       input int exp_lat, input bit restart);
    int s0;
    int d0;
    int k;
    @(posedge clock);
    #1;
    s0 = tot_shifts;
    d0 = tot_dones;
    begin_drain(words);
    outReady = pat[0];
    k = 0;
    while (tot_dones == d0 && k < 200) begin
      @(posedge clock);
      #1;
      k++;
      start    = (restart && k == 2);
      outReady = pat[k % 4];
    end
    start = 1'b0;
    check("done_seen", (tot_dones > d0), 1'b1);
    check("shift_count", tot_shifts - s0, ROWS);
    if (exp_lat != 0) check("start_to_done", done_cyc - start_cyc, exp_lat);
    outReady = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("done_once", tot_dones - d0, 1);
    check("busy_after", busy, 1'b0);
    check("scoreboard_empty", sb_q.size(), 0);
  endtask

  typedef struct {
    logic [3:0][W-1:0] words;
    logic [3:0]        pat;
    int                lat;
    bit                restart;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int s0;
    int d0;
    int k;

    // Word index 0 is the bottom PE (first out); pattern bit 0 applies in the start cycle.
    vecs[0] = '{words: {32'h44, 32'h33, 32'h22, 32'h11}, pat: 4'b1111, lat: 6, restart: 0};
    vecs[1] = '{words: {32'h0000_0000, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 32'hA5A5_A5A5},
                pat: 4'b1010, lat: 0, restart: 0};
    vecs[2] = '{words: {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001},
                pat: 4'b1100, lat: 0, restart: 0};
    vecs[3] = '{words: {32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 32'h8000_0000},
                pat: 4'b1111, lat: 6, restart: 1};
    vecs[4] = '{words: {32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
                pat: 4'b0110, lat: 0, restart: 1};

    reset    = 1'b1;
    start    = 1'b0;
    outReady = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_valid", outValid, 1'b0);
    check("reset_data", outData, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_enable", enableShiftOut, 1'b0);
    check("reset_done", done, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drain(vecs[i].words, vecs[i].pat, vecs[i].lat, vecs[i].restart);
    end

    // Backpressure: no readiness, the column stalls after DEPTH shifts.
    @(posedge clock);
    #1;
    outReady = 1'b0;
    s0 = tot_shifts;
    d0 = tot_dones;
    begin_drain({32'hB004, 32'hB003, 32'hB002, 32'hB001});
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("bp_shifts_stalled", tot_shifts - s0, DEPTH);
    check("bp_valid", outValid, 1'b1);
    check("bp_enable_low", enableShiftOut, 1'b0);
    check("bp_busy", busy, 1'b1);
    check("bp_no_done", done, 1'b0);
    @(posedge clock);
    #1;
    outReady = 1'b1;
    k = 0;
    while (tot_dones == d0 && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("bp_done_seen", (tot_dones > d0), 1'b1);
    check("bp_shift_count", tot_shifts - s0, ROWS);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("bp_done_once", tot_dones - d0, 1);
    check("bp_scoreboard_empty", sb_q.size(), 0);

    // Reset mid-drain, then a fresh drain.
    @(posedge clock);
    #1;
    outReady = 1'b0;
    s0 = tot_shifts;
    begin_drain({32'hD004, 32'hD003, 32'hD002, 32'hD001});
    @(posedge clock);
    #1;
    start = 1'b0;
    k = 0;
    while (tot_shifts - s0 < 2 && k < 50) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("rst_mid_two_shifts", tot_shifts - s0, 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_valid", outValid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_enable", enableShiftOut, 1'b0);
    check("rst_mid_done", done, 1'b0);
    drain({32'hE004, 32'hE003, 32'hE002, 32'hE001}, 4'b1111, 6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
